// File: rtl/axi_wr_arbiter.sv
// Round-robin write-channel arbiter between masters M0 and M1 sharing one slave AW/W path.
// One write is outstanding at a time; the grant is held until the owner's B handshake.
module axi_wr_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [3:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [3:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [ID_W+3:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [3:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic                b_hs,
    input  logic [1:0]          b_mid,
    output logic [1:0]          grant,
    output logic                wlast_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_owner_q, last_owner_d;   // 1'b1 means M1 owned last
    logic [3:0]  len_q, len_d;
    logic [3:0]  beat_q, beat_d;
    logic        wlast_err_q, wlast_err_d;

    logic                sel_m1_s;
    logic [ID_W-1:0]     sel_awid_s;
    logic [ADDR_W-1:0]   sel_awaddr_s;
    logic [3:0]          sel_awlen_s;
    logic [2:0]          sel_awsize_s;
    logic [1:0]          sel_awburst_s;
    logic                sel_awvalid_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [DATA_W/8-1:0] sel_wstrb_s;
    logic                sel_wlast_s;
    logic                sel_wvalid_s;

    assign sel_m1_s      = grant_q[1];
    assign sel_awid_s    = sel_m1_s ? m1_awid    : m0_awid;
    assign sel_awaddr_s  = sel_m1_s ? m1_awaddr  : m0_awaddr;
    assign sel_awlen_s   = sel_m1_s ? m1_awlen   : m0_awlen;
    assign sel_awsize_s  = sel_m1_s ? m1_awsize  : m0_awsize;
    assign sel_awburst_s = sel_m1_s ? m1_awburst : m0_awburst;
    assign sel_awvalid_s = sel_m1_s ? m1_awvalid : m0_awvalid;
    assign sel_wdata_s   = sel_m1_s ? m1_wdata   : m0_wdata;
    assign sel_wstrb_s   = sel_m1_s ? m1_wstrb   : m0_wstrb;
    assign sel_wlast_s   = sel_m1_s ? m1_wlast   : m0_wlast;
    assign sel_wvalid_s  = sel_m1_s ? m1_wvalid  : m0_wvalid;

    assign grant     = grant_q;
    assign wlast_err = wlast_err_q;

    // Next-state logic and the combinational AW/W forwarding of the granted master.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        len_d        = len_q;
        beat_d       = beat_q;
        wlast_err_d  = wlast_err_q;
        s_awid       = {(ID_W+4){1'b0}};
        s_awaddr     = {ADDR_W{1'b0}};
        s_awlen      = 4'd0;
        s_awsize     = 3'd0;
        s_awburst    = 2'd0;
        s_awvalid    = 1'b0;
        s_wdata      = {DATA_W{1'b0}};
        s_wstrb      = {(DATA_W/8){1'b0}};
        s_wlast      = 1'b0;
        s_wvalid     = 1'b0;
        m0_awready   = 1'b0;
        m1_awready   = 1'b0;
        m0_wready    = 1'b0;
        m1_wready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On a tie the master that did not own the previous write wins.
                if (m0_awvalid && m1_awvalid) begin
                    grant_d = last_owner_q ? 2'b01 : 2'b10;
                    state_d = S_ADDR;
                end else if (m0_awvalid) begin
                    grant_d = 2'b01;
                    state_d = S_ADDR;
                end else if (m1_awvalid) begin
                    grant_d = 2'b10;
                    state_d = S_ADDR;
                end else begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                s_awid    = {2'b00, grant_q, sel_awid_s};
                s_awaddr  = sel_awaddr_s;
                s_awlen   = sel_awlen_s;
                s_awsize  = sel_awsize_s;
                s_awburst = sel_awburst_s;
                s_awvalid = sel_awvalid_s;
                if (sel_m1_s) begin
                    m1_awready = s_awready;
                end else begin
                    m0_awready = s_awready;
                end
                if (sel_awvalid_s && s_awready) begin
                    len_d   = sel_awlen_s;
                    beat_d  = 4'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                s_wdata  = sel_wdata_s;
                s_wstrb  = sel_wstrb_s;
                s_wlast  = sel_wlast_s;
                s_wvalid = sel_wvalid_s;
                if (sel_m1_s) begin
                    m1_wready = s_wready;
                end else begin
                    m0_wready = s_wready;
                end
                if (sel_wvalid_s && s_wready) begin
                    beat_d = beat_q + 4'd1;
                    if (sel_wlast_s) begin
                        state_d = S_RESP;
                        // beat_q is the zero-based index of this last beat.
                        if (beat_q != len_q) begin
                            wlast_err_d = 1'b1;
                        end else begin
                            wlast_err_d = wlast_err_q;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                if (b_hs && (b_mid == grant_q)) begin
                    last_owner_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            len_q        <= 4'd0;
            beat_q       <= 4'd0;
            wlast_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            wlast_err_q  <= wlast_err_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: queues hold expected AW/W beats, popped on slave-side handshakes.
module tb_axi_wr_arbiter;

    logic        clk, rst;
    logic [3:0]  m0_awid, m1_awid;
    logic [31:0] m0_awaddr, m1_awaddr;
    logic [3:0]  m0_awlen, m1_awlen;
    logic [2:0]  m0_awsize, m1_awsize;
    logic [1:0]  m0_awburst, m1_awburst;
    logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
    logic [7:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready;
    logic        b_hs;
    logic [1:0]  b_mid;
    logic [1:0]  grant;
    logic        wlast_err;

    int          checks = 0;
    int          failures = 0;
    int          cur_m = -1;
    int          ac;
    bit          last_aw_hs, last_w_hs;
    logic        exp_err;
    logic [63:0] exp_aw[$];
    logic [63:0] exp_w[$];

    axi_wr_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
        .m0_awburst(m0_awburst), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
        .m0_wready(m0_wready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
        .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
        .m1_wready(m1_wready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .b_hs(b_hs), .b_mid(b_mid), .grant(grant), .wlast_err(wlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] code(input int m);
        return (m == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic get_awready(input int m);
        return (m == 0) ? m0_awready : m1_awready;
    endfunction

    function automatic logic get_wready(input int m);
        return (m == 0) ? m0_wready : m1_wready;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_aw(input int m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic v);
        if (m == 0) begin
            m0_awid = id; m0_awaddr = addr; m0_awlen = len;
            m0_awsize = 3'd2; m0_awburst = 2'b01; m0_awvalid = v;
        end else begin
            m1_awid = id; m1_awaddr = addr; m1_awlen = len;
            m1_awsize = 3'd2; m1_awburst = 2'b01; m1_awvalid = v;
        end
    endtask

    task automatic set_w(input int m, input logic [31:0] d, input logic [3:0] st,
                         input logic lst, input logic v);
        if (m == 0) begin
            m0_wdata = d; m0_wstrb = st; m0_wlast = lst; m0_wvalid = v;
        end else begin
            m1_wdata = d; m1_wstrb = st; m1_wlast = lst; m1_wvalid = v;
        end
    endtask

    // Observe slave-side handshakes for this cycle, score them, then advance one clock.
    task automatic step();
        logic [63:0] e;
        #1;
        last_aw_hs = s_awvalid && s_awready;
        last_w_hs  = s_wvalid && s_wready;
        if (last_aw_hs) begin
            chk("aw_expected", exp_aw.size() > 0, 1'b1);
            if (exp_aw.size() > 0) begin
                e = exp_aw.pop_front();
                chk("aw_beat", {15'd0, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst}, e);
            end
        end
        if (last_w_hs) begin
            chk("w_expected", exp_w.size() > 0, 1'b1);
            if (exp_w.size() > 0) begin
                e = exp_w.pop_front();
                chk("w_beat", {27'd0, s_wdata, s_wstrb, s_wlast}, e);
            end
        end
        if (cur_m >= 0) begin
            chk("other_master_rdy", {get_awready(1 - cur_m), get_wready(1 - cur_m)}, 2'b00);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int m, input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input int nbeats, input bit tog,
                       input bit wrong_b, output int aw_cycles);
        int          cyc;
        logic [31:0] d;
        logic [3:0]  st;
        logic        lst;
        cur_m = m;
        set_aw(m, id, addr, len, 1'b1);
        exp_aw.push_back({15'd0, 2'b00, code(m), id, addr, len, 3'd2, 2'b01});
        cyc = 0;
        do begin
            #1;
            chk("awready_fwd", get_awready(m), s_awvalid && s_awready);
            step();
            cyc++;
        end while (!last_aw_hs && cyc < 40);
        aw_cycles = cyc;
        chk("aw_hs_seen", last_aw_hs, 1'b1);
        set_aw(m, id, addr, len, 1'b0);
        chk("grant_owner", grant, code(m));
        for (int b = 0; b < nbeats; b++) begin
            d   = $urandom;
            st  = 4'(b + 1);
            lst = (b == nbeats - 1);
            set_w(m, d, st, lst, 1'b1);
            exp_w.push_back({27'd0, d, st, lst});
            cyc = 0;
            do begin
                if (tog) s_wready = ~s_wready;
                #1;
                chk("wready_fwd", get_wready(m), s_wvalid && s_wready);
                step();
                cyc++;
            end while (!last_w_hs && cyc < 40);
            chk("w_hs_seen", last_w_hs, 1'b1);
        end
        set_w(m, 32'd0, 4'd0, 1'b0, 1'b0);
        s_wready = 1'b1;
        if (nbeats != int'(len) + 1) exp_err = 1'b1;
        chk("resp_grant", grant, code(m));
        chk("resp_awvalid", s_awvalid, 1'b0);
        chk("resp_wvalid", s_wvalid, 1'b0);
        chk("wlast_err", wlast_err, exp_err);
        if (wrong_b) begin
            b_hs = 1'b1; b_mid = code(1 - m);
            step();
            b_hs = 1'b0;
            chk("wrong_bmid_hold", grant, code(m));
        end
        b_hs = 1'b1; b_mid = code(m);
        step();
        b_hs = 1'b0; b_mid = 2'b00;
        chk("released", grant, 2'b00);
        cur_m = -1;
    endtask

    initial begin
        rst = 1'b1; b_hs = 1'b0; b_mid = 2'b00; s_awready = 1'b1; s_wready = 1'b1; exp_err = 1'b0;
        set_aw(0, 4'd0, 32'd0, 4'd0, 1'b0);
        set_aw(1, 4'd0, 32'd0, 4'd0, 1'b0);
        set_w(0, 32'd0, 4'd0, 1'b0, 1'b0);
        set_w(1, 32'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1; @(posedge clk); #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_wlast_err", wlast_err, 1'b0);
        chk("rst_valids", {s_awvalid, s_wvalid}, 2'b00);
        chk("rst_readys", {m0_awready, m1_awready, m0_wready, m1_wready}, 4'h0);
        chk("rst_awaddr", s_awaddr, 32'd0);
        rst = 1'b0;

        // Single-beat M0 write: s_awid 8'h13, one-cycle grant latency.
        txn(0, 4'd3, 32'h1000_0000, 4'd0, 1, 1'b0, 1'b0, ac);
        chk("grant_latency", ac, 2);
        chk("idle_awid", s_awid, 8'h00);

        // M1 four-beat burst with s_wready toggling.
        txn(1, 4'hA, 32'h2000_0040, 4'd3, 4, 1'b1, 1'b0, ac);

        // Simultaneous requests, round-robin M0 -> M1 -> M0; wrong b_mid ignored on the last.
        set_aw(1, 4'h6, 32'h3000_0000, 4'd1, 1'b1);
        txn(0, 4'h5, 32'h4000_0000, 4'd0, 1, 1'b0, 1'b0, ac);
        set_aw(0, 4'h9, 32'h4000_0100, 4'd0, 1'b1);
        txn(1, 4'h6, 32'h3000_0000, 4'd1, 2, 1'b0, 1'b0, ac);
        txn(0, 4'h9, 32'h4000_0100, 4'd0, 1, 1'b0, 1'b1, ac);

        // Short burst sets the sticky error; a clean write afterwards leaves it set.
        txn(0, 4'h1, 32'h5000_0000, 4'd3, 3, 1'b0, 1'b0, ac);
        txn(1, 4'h2, 32'h5000_1000, 4'd1, 2, 1'b0, 1'b0, ac);

        // Asynchronous reset in the middle of DATA.
        cur_m = 0;
        set_aw(0, 4'h2, 32'h6000_0000, 4'd1, 1'b1);
        exp_aw.push_back({15'd0, 2'b00, 2'b01, 4'h2, 32'h6000_0000, 4'd1, 3'd2, 2'b01});
        ac = 0;
        do begin
            step();
            ac++;
        end while (!last_aw_hs && ac < 40);
        chk("rst_test_aw_hs", last_aw_hs, 1'b1);
        set_aw(0, 4'h2, 32'h6000_0000, 4'd1, 1'b0);
        s_wready = 1'b0;
        set_w(0, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1);
        #1;
        chk("pre_rst_wvalid", s_wvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_grant", grant, 2'b00);
        chk("async_rst_wvalid", s_wvalid, 1'b0);
        chk("async_rst_awvalid", s_awvalid, 1'b0);
        chk("async_rst_wlast_err", wlast_err, 1'b0);
        set_w(0, 32'd0, 4'd0, 1'b0, 1'b0);
        exp_w.delete();
        exp_err = 1'b0;
        cur_m = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_wready = 1'b1;

        // After reset M0 wins the first tie again.
        set_aw(1, 4'h7, 32'h7000_0000, 4'd0, 1'b1);
        txn(0, 4'h4, 32'h7000_1000, 4'd0, 1, 1'b0, 1'b0, ac);
        set_aw(1, 4'h7, 32'h7000_0000, 4'd0, 1'b0);
        step();
        chk("final_grant_idle", grant, 2'b00);
        chk("aw_queue_empty", exp_aw.size(), 0);
        chk("w_queue_empty", exp_w.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Write-channel arbiter that shares the single slave-side AW/W path of the AXI bridge between master M0 and master M1. It grants one write transaction at a time with round-robin priority, forwards the granted master's AW and W channels, and tags the slave-side ID with the master code. It holds the grant until that master's B handshake completes at the write-response multiplexer. This allows exactly one outstanding write per bridge.

## Interface
Parameters:
- ID_W, 4, master-side AXI ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width (WSTRB width = DATA_W/8)

Ports (mX = m0, m1):
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous assertion, active-high
- mX_awid / mX_awaddr / mX_awlen / mX_awsize / mX_awburst  in  ID_W / ADDR_W / 4 / 3 / 2  master write address
- mX_awvalid  in  1 ; mX_awready  out  1  master AW handshake
- mX_wdata / mX_wstrb / mX_wlast / mX_wvalid  in  DATA_W / DATA_W/8 / 1 / 1  master write data
- mX_wready  out  1  master W ready
- s_awid  out  ID_W+4  {2'b00, master code, awid}; master code is bits [ID_W+1:ID_W]; M0=2'b01, M1=2'b10
- s_awaddr / s_awlen / s_awsize / s_awburst / s_awvalid  out  widths as master side
- s_awready  in  1  slave-side AW ready
- s_wdata / s_wstrb / s_wlast / s_wvalid  out  slave-side write data
- s_wready  in  1  slave-side W ready
- b_hs  in  1  B handshake completed at master side (BVALID & BREADY) this cycle
- b_mid  in  2  master code of that B response
- grant  out  2  one-hot owner {M1, M0}; 0 when idle
- wlast_err  out  1  sticky; WLAST beat count disagreed with AWLEN

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Reset: IDLE, grant=0, last_owner=M1 (M0 wins first tie), wlast_err=0, beat counter 0, all s_* valids and all master readys 0.
- IDLE: if any mX_awvalid, register the winner into grant and move to ADDR. One requester wins alone. If both request, the master that is not last_owner wins. No request means stay in IDLE.
- ADDR: s_aw* = granted master's aw* (combinational). The granted mX_awready = s_awready. On s_awvalid & s_awready, latch awlen into len_q, clear the beat counter, and go to DATA. All W readys are 0 in this state.
- DATA: s_w* = granted master's w*. The granted mX_wready = s_wready. Each W handshake increments the beat counter (4-bit, wraps at 15). A handshake with wlast goes to RESP. If the counter differs from len_q on the wlast beat, set wlast_err.
- RESP: no AW or W forwarding. On b_hs & (b_mid == granted code): last_owner = granted master, grant = 0, go to IDLE.
- A b_hs with a non-matching b_mid is ignored in every state.
- The non-granted master always sees awready=0 and wready=0. Its awvalid is held off, never dropped.
- wlast_err clears only on rst.
- Data and address outputs are don't-care when the corresponding valid is 0. Drive them to 0 while idle.

## Timing
- Grant latency: 1 cycle from awvalid in IDLE to s_awvalid in ADDR.
- AW and W forwarding are zero-latency combinational paths. There are no skid registers.
- Minimum transaction for single beat with all readys high is 5 cycles: IDLE, ADDR, DATA, RESP, IDLE. A new grant is issued in the IDLE cycle after b_hs.
- If b_hs arrives in the same cycle that the FSM enters RESP, it is not seen. It must arrive while in RESP. The response mux cannot produce B earlier.
- Asynchronous rst mid-transaction returns to reset values immediately and drops all s_* valids. Any in-flight slave-side transaction is abandoned.

## Test plan
- Reset, then M0 issues AWID=3, AWADDR=0x1000_0000, AWLEN=0, single W beat with wlast, b_hs with b_mid=01 -> s_awid=8'h13, grant=01 then 00, wlast_err=0, FSM back to IDLE.
- M0 and M1 assert awvalid in the same cycle, repeated twice -> first grant to M0, second to M1; M1's awready stays 0 during M0's transaction.
- M1 burst AWLEN=3 with s_wready toggling every other cycle -> exactly 4 beats forwarded in order, s_awid[5:4]=10, DATA exits only on the wlast handshake.
- M0 burst AWLEN=3 with wlast on beat 2 -> wlast_err=1 and stays 1 through later good transactions until rst.
- While M0 is in RESP, b_hs with b_mid=10 -> ignored, grant stays 01; a following b_hs with b_mid=01 releases the grant.
- rst asserted during DATA -> grant=0, s_wvalid=0, s_awvalid=0 without waiting for a clock edge; after release, M0 wins the first arbitration.
